// File: rtl/mux_32.sv
// 32-to-1 selector over individually named inputs, with a combinational result
// and a registered copy for pipelined consumers.
module mux_32 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       select,
  input  logic [WIDTH-1:0] in00,
  input  logic [WIDTH-1:0] in01,
  input  logic [WIDTH-1:0] in02,
  input  logic [WIDTH-1:0] in03,
  input  logic [WIDTH-1:0] in04,
  input  logic [WIDTH-1:0] in05,
  input  logic [WIDTH-1:0] in06,
  input  logic [WIDTH-1:0] in07,
  input  logic [WIDTH-1:0] in08,
  input  logic [WIDTH-1:0] in09,
  input  logic [WIDTH-1:0] in10,
  input  logic [WIDTH-1:0] in11,
  input  logic [WIDTH-1:0] in12,
  input  logic [WIDTH-1:0] in13,
  input  logic [WIDTH-1:0] in14,
  input  logic [WIDTH-1:0] in15,
  input  logic [WIDTH-1:0] in16,
  input  logic [WIDTH-1:0] in17,
  input  logic [WIDTH-1:0] in18,
  input  logic [WIDTH-1:0] in19,
  input  logic [WIDTH-1:0] in20,
  input  logic [WIDTH-1:0] in21,
  input  logic [WIDTH-1:0] in22,
  input  logic [WIDTH-1:0] in23,
  input  logic [WIDTH-1:0] in24,
  input  logic [WIDTH-1:0] in25,
  input  logic [WIDTH-1:0] in26,
  input  logic [WIDTH-1:0] in27,
  input  logic [WIDTH-1:0] in28,
  input  logic [WIDTH-1:0] in29,
  input  logic [WIDTH-1:0] in30,
  input  logic [WIDTH-1:0] in31,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] in_arr [32];
  logic [WIDTH-1:0] out_d;

  // Gather the named ports so select can index them directly; an X/Z select
  // yields X in simulation rather than an arbitrary input.
  assign in_arr[0]  = in00;
  assign in_arr[1]  = in01;
  assign in_arr[2]  = in02;
  assign in_arr[3]  = in03;
  assign in_arr[4]  = in04;
  assign in_arr[5]  = in05;
  assign in_arr[6]  = in06;
  assign in_arr[7]  = in07;
  assign in_arr[8]  = in08;
  assign in_arr[9]  = in09;
  assign in_arr[10] = in10;
  assign in_arr[11] = in11;
  assign in_arr[12] = in12;
  assign in_arr[13] = in13;
  assign in_arr[14] = in14;
  assign in_arr[15] = in15;
  assign in_arr[16] = in16;
  assign in_arr[17] = in17;
  assign in_arr[18] = in18;
  assign in_arr[19] = in19;
  assign in_arr[20] = in20;
  assign in_arr[21] = in21;
  assign in_arr[22] = in22;
  assign in_arr[23] = in23;
  assign in_arr[24] = in24;
  assign in_arr[25] = in25;
  assign in_arr[26] = in26;
  assign in_arr[27] = in27;
  assign in_arr[28] = in28;
  assign in_arr[29] = in29;
  assign in_arr[30] = in30;
  assign in_arr[31] = in31;

  always_comb begin
    out_d = in_arr[select];
  end

  assign out = out_d;

  // Registered copy: one cycle behind out, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_mux_32.sv
// Directed bench for mux_32: one 1-bit and one 8-bit instance, with expected
// values queued by the stimulus and checked by an independent monitor.
module tb_mux_32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  sel1;
  logic [4:0]  sel8;
  logic [31:0] d1;
  logic [7:0]  d8 [32];
  logic        out1, out_q1;
  logic [7:0]  out8, out_q8;

  typedef struct {
    int         sig;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;
  logic stim_done = 1'b0;

  mux_32 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .select(sel1),
    .in00(d1[0]),  .in01(d1[1]),  .in02(d1[2]),  .in03(d1[3]),
    .in04(d1[4]),  .in05(d1[5]),  .in06(d1[6]),  .in07(d1[7]),
    .in08(d1[8]),  .in09(d1[9]),  .in10(d1[10]), .in11(d1[11]),
    .in12(d1[12]), .in13(d1[13]), .in14(d1[14]), .in15(d1[15]),
    .in16(d1[16]), .in17(d1[17]), .in18(d1[18]), .in19(d1[19]),
    .in20(d1[20]), .in21(d1[21]), .in22(d1[22]), .in23(d1[23]),
    .in24(d1[24]), .in25(d1[25]), .in26(d1[26]), .in27(d1[27]),
    .in28(d1[28]), .in29(d1[29]), .in30(d1[30]), .in31(d1[31]),
    .out(out1), .out_q(out_q1)
  );

  mux_32 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .select(sel8),
    .in00(d8[0]),  .in01(d8[1]),  .in02(d8[2]),  .in03(d8[3]),
    .in04(d8[4]),  .in05(d8[5]),  .in06(d8[6]),  .in07(d8[7]),
    .in08(d8[8]),  .in09(d8[9]),  .in10(d8[10]), .in11(d8[11]),
    .in12(d8[12]), .in13(d8[13]), .in14(d8[14]), .in15(d8[15]),
    .in16(d8[16]), .in17(d8[17]), .in18(d8[18]), .in19(d8[19]),
    .in20(d8[20]), .in21(d8[21]), .in22(d8[22]), .in23(d8[23]),
    .in24(d8[24]), .in25(d8[25]), .in26(d8[26]), .in27(d8[27]),
    .in28(d8[28]), .in29(d8[29]), .in30(d8[30]), .in31(d8[31]),
    .out(out8), .out_q(out_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue an expectation and let the monitor sample the DUT now.
  task automatic expect_val(input int sig, input logic [7:0] v, input string nm);
    exp_t e;
    e.sig = sig;
    e.exp = v;
    e.name = nm;
    q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  // Monitor: pop each queued expectation and compare with the live DUT value.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sig)
          0:       act = {7'b0, out1};
          1:       act = {7'b0, out_q1};
          2:       act = out8;
          default: act = out_q8;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    sel1  = '0;
    sel8  = '0;
    d1    = '0;
    for (int i = 0; i < 32; i++) d8[i] = '0;
    #2;
    expect_val(1, 8'h00, "reset_out_q1");
    expect_val(3, 8'h00, "reset_out_q8");

    // Sweep all selects over a random pattern.
    d  = $urandom;
    d1 = d;
    for (int i = 0; i < 32; i++) begin
      sel1 = i[4:0];
      #1;
      expect_val(0, {7'b0, d[i]}, $sformatf("sweep_sel%0d", i));
    end

    // Walking one.
    for (int k = 0; k < 32; k++) begin
      d1 = 32'h1 << k;
      for (int s = 0; s < 32; s++) begin
        sel1 = s[4:0];
        #1;
        expect_val(0, (s == k) ? 8'h01 : 8'h00, $sformatf("walk_k%0d_s%0d", k, s));
      end
    end

    // Selected input toggles; neighbours do not disturb out.
    sel1 = 5'd17;
    d1   = '0;
    #1; expect_val(0, 8'h00, "tog_in17_0");
    d1[17] = 1'b1; #1; expect_val(0, 8'h01, "tog_in17_1");
    d1[16] = 1'b1; #1; expect_val(0, 8'h01, "tog_in16_hi_keep1");
    d1[18] = 1'b1; #1; expect_val(0, 8'h01, "tog_in18_hi_keep1");
    d1[17] = 1'b0; #1; expect_val(0, 8'h00, "tog_in17_back0");
    d1[16] = 1'b0; #1; expect_val(0, 8'h00, "tog_in16_lo_keep0");

    // Boundary selects on the 8-bit instance.
    d8[0]  = 8'hA5;
    d8[31] = 8'h5A;
    sel8 = 5'd0;  #1; expect_val(2, 8'hA5, "w8_sel0");
    sel8 = 5'd31; #1; expect_val(2, 8'h5A, "w8_sel31");
    sel8 = 5'd1;  #1; expect_val(2, 8'h00, "w8_sel1");
    sel8 = 5'd30; #1; expect_val(2, 8'h00, "w8_sel30");

    // Registered path.
    @(negedge clk);
    d1 = '0;
    d1[5] = 1'b1;
    sel1 = 5'd5;
    sel8 = 5'd0;
    #1; expect_val(1, 8'h00, "outq_held_in_reset");
    rst_n = 1'b1;
    #1; expect_val(1, 8'h00, "outq_before_edge");
    @(posedge clk); #1;
    expect_val(1, 8'h01, "outq_after_edge1");
    expect_val(3, 8'hA5, "outq8_after_edge1");
    @(negedge clk);
    sel1 = 5'd6;
    #1; expect_val(1, 8'h01, "outq_hold_midcycle");
    @(posedge clk); #1;
    expect_val(1, 8'h00, "outq_sel6");

    // Async reset mid-cycle.
    @(negedge clk);
    sel1 = 5'd5;
    @(posedge clk); #1;
    expect_val(1, 8'h01, "outq_set_again");
    #2;
    rst_n = 1'b0;
    #1;
    expect_val(1, 8'h00, "async_rst_outq");
    expect_val(3, 8'h00, "async_rst_outq8");
    expect_val(0, 8'h01, "async_rst_out_live");
    @(negedge clk);
    rst_n = 1'b1;
    #1; expect_val(1, 8'h00, "rel_outq_wait");
    @(posedge clk); #1;
    expect_val(1, 8'h01, "rel_outq_after_edge");

    #5;
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
